// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle RV32-subset control path.
// Contents: FSM state encodings, opcode constants, ALU operation codes,
// ALUSrcB select codes, the per-cycle control bundle and a small helper.
package mc_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned FUNCT_W  = 4;
    localparam int unsigned ALU_OP_W = 4;
    localparam int unsigned SRCB_W   = 2;
    localparam int unsigned WAIT_W   = 8;

    // FSM states; encodings 10-15 are unused and recover to FETCH.
    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    // Supported RV32 opcodes (IR[6:0]).
    localparam logic [OPCODE_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LW  = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_SW  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BEQ = 7'b1100011;

    // ALU operation codes.
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0110;

    // ALU B-operand selects.
    localparam logic [SRCB_W-1:0] SRCB_RS2  = 2'b00;
    localparam logic [SRCB_W-1:0] SRCB_FOUR = 2'b01;
    localparam logic [SRCB_W-1:0] SRCB_IMM  = 2'b10;

    // Datapath enables and selects produced each cycle.
    typedef struct packed {
        logic              pc_write;
        logic              pc_src;
        logic              i_or_d;
        logic              mem_read;
        logic              mem_write;
        logic              ir_write;
        logic              mem_to_reg;
        logic              reg_write;
        logic              alu_src_a;
        logic [SRCB_W-1:0] alu_src_b;
    } ctl_t;

    // States that own the shared memory port and wait on mem_ready.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational ALU operation decode from FSM state and {IR[30], funct3}.
// Ports:
//   i_state     current FSM state
//   i_funct     {IR[30], IR[14:12]}
//   o_operation ALU operation code
module mc_alu_decode
    import mc_pkg::*;
(
    input  logic [STATE_W-1:0]  i_state,
    input  logic [FUNCT_W-1:0]  i_funct,
    output logic [ALU_OP_W-1:0] o_operation
);

    // Address/PC arithmetic states add; unused encodings drive all-zero.
    always_comb begin
        o_operation = ALU_ADD;
        case (i_state)
            S_EXEC_R: begin
                case (i_funct)
                    4'b1000: o_operation = ALU_SUB;
                    4'b0111: o_operation = ALU_AND;
                    4'b0110: o_operation = ALU_OR;
                    default: o_operation = ALU_ADD;
                endcase
            end
            // IR[30] carries immediate bits for I-type, so only funct3 counts.
            S_EXEC_I: begin
                case (i_funct[2:0])
                    3'b111:  o_operation = ALU_AND;
                    3'b110:  o_operation = ALU_OR;
                    default: o_operation = ALU_ADD;
                endcase
            end
            S_BRANCH: o_operation = ALU_SUB;
            S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD,
            S_MEM_WB, S_MEM_WR, S_ALU_WB: o_operation = ALU_ADD;
            default: o_operation = ALU_OP_W'(0);
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the RV32 subset (R, I-ALU, lw, sw, beq).
// Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB, drives the
// datapath enables and selects, and stalls on the memory-ready handshake
// with an optional wait timeout.
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   Opcode, Funct       IR[6:0] and {IR[30], IR[14:12]}
//   Zero                ALU zero flag (branch decision)
//   mem_ready           memory completes the current access this cycle
//   PCWrite..ALUSrcB    datapath enables and mux selects
//   Operation           ALU operation code
//   state               current FSM state (debug)
//   illegal_op          pulse in DECODE on an unsupported opcode
//   mem_timeout         sticky memory-wait overflow flag
module multicycle_control
    import mc_pkg::*;
#(
    parameter logic [STATE_W-1:0] RESET_STATE = 4'd0,
    parameter logic [WAIT_W-1:0]  MEM_TIMEOUT = 8'd255
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic [FUNCT_W-1:0]  Funct,
    input  logic                Zero,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCSrc,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [SRCB_W-1:0]   ALUSrcB,
    output logic [ALU_OP_W-1:0] Operation,
    output logic [STATE_W-1:0]  state,
    output logic                illegal_op,
    output logic                mem_timeout
);

    state_t              r_state;
    state_t              w_next;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                r_mem_timeout;
    logic                w_in_mem;
    logic                w_timeout;
    logic                w_illegal;
    ctl_t                w_ctl;
    ctl_t                w_out;
    logic [ALU_OP_W-1:0] w_alu_op;

    mc_alu_decode u_alu_decode (
        .i_state     (r_state),
        .i_funct     (Funct),
        .o_operation (w_alu_op)
    );

    // The counter is cleared on every state change, so it never holds
    // MEM_TIMEOUT itself: the overflow is taken on the wait cycle that
    // would bring it there.
    assign w_in_mem  = is_mem_state(r_state);
    assign w_timeout = (MEM_TIMEOUT != WAIT_W'(0)) && w_in_mem && !mem_ready &&
                       (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - WAIT_W'(1)));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= state_t'(RESET_STATE);
        end else begin
            r_state <= w_next;
        end
    end

    // Wait counter (saturating) and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt    <= WAIT_W'(0);
            r_mem_timeout <= 1'b0;
        end else begin
            if ((r_state != w_next) || w_timeout) begin
                r_wait_cnt <= WAIT_W'(0);
            end else if (w_in_mem && !mem_ready && (r_wait_cnt != {WAIT_W{1'b1}})) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
            if (w_timeout) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

    // Next-state and Moore control decode (mem_ready/Zero qualify a few enables).
    always_comb begin
        w_next    = S_FETCH;
        w_ctl     = '0;
        w_illegal = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ctl.mem_read  = 1'b1;
                w_ctl.alu_src_b = SRCB_FOUR;
                w_next          = S_FETCH;
                if (mem_ready) begin
                    w_ctl.ir_write = 1'b1;
                    w_ctl.pc_write = 1'b1;
                    w_next         = S_DECODE;
                end
            end
            // Branch target (PC + imm) is computed here into ALUOut.
            S_DECODE: begin
                w_ctl.alu_src_b = SRCB_IMM;
                case (Opcode)
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_R:         w_next = S_EXEC_R;
                    OP_I:         w_next = S_EXEC_I;
                    OP_BEQ:       w_next = S_BRANCH;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = SRCB_IMM;
                if (Opcode == OP_SW) begin
                    w_next = S_MEM_WR;
                end else if (Opcode == OP_LW) begin
                    w_next = S_MEM_RD;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_MEM_RD: begin
                w_ctl.i_or_d   = 1'b1;
                w_ctl.mem_read = 1'b1;
                w_next         = mem_ready ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                w_ctl.reg_write  = 1'b1;
                w_ctl.mem_to_reg = 1'b1;
                w_next           = S_FETCH;
            end
            S_MEM_WR: begin
                w_ctl.i_or_d    = 1'b1;
                w_ctl.mem_write = 1'b1;
                w_next          = mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_EXEC_R: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = SRCB_RS2;
                w_next          = S_ALU_WB;
            end
            S_EXEC_I: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = SRCB_IMM;
                w_next          = S_ALU_WB;
            end
            S_ALU_WB: begin
                w_ctl.reg_write = 1'b1;
                w_next          = S_FETCH;
            end
            S_BRANCH: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = SRCB_RS2;
                w_ctl.pc_src    = 1'b1;
                w_ctl.pc_write  = Zero;
                w_next          = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
        if (w_timeout) begin
            w_next = S_FETCH;
        end
    end

    // Requests are masked while reset is held so no access outlives reset.
    always_comb begin
        w_out = reset ? ctl_t'(0) : w_ctl;
    end

    assign PCWrite     = w_out.pc_write;
    assign PCSrc       = w_out.pc_src;
    assign IorD        = w_out.i_or_d;
    assign MemRead     = w_out.mem_read;
    assign MemWrite    = w_out.mem_write;
    assign IRWrite     = w_out.ir_write;
    assign MemtoReg    = w_out.mem_to_reg;
    assign RegWrite    = w_out.reg_write;
    assign ALUSrcA     = w_out.alu_src_a;
    assign ALUSrcB     = w_out.alu_src_b;
    assign Operation   = reset ? ALU_ADD : w_alu_op;
    assign state       = r_state;
    assign illegal_op  = w_illegal & ~reset;
    assign mem_timeout = r_mem_timeout;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each stimulus cycle pushes the
// hand-computed expected output vector; a negedge monitor pops and compares.
module tb_multicycle_control;

    // Expected output vector; ctl order is
    // PCWrite PCSrc IorD MemRead MemWrite IRWrite MemtoReg RegWrite ALUSrcA.
    typedef struct packed {
        logic [3:0] st;
        logic [8:0] ctl;
        logic [1:0] srcb;
        logic [3:0] op;
        logic       ill;
        logic       tmo;
    } exp_t;

    localparam logic [8:0] C_NONE    = 9'b000000000;
    localparam logic [8:0] C_FETCH_W = 9'b000100000;
    localparam logic [8:0] C_FETCH_R = 9'b100101000;
    localparam logic [8:0] C_SRCA    = 9'b000000001;
    localparam logic [8:0] C_MRD     = 9'b001100000;
    localparam logic [8:0] C_MWB     = 9'b000000110;
    localparam logic [8:0] C_MWR     = 9'b001010000;
    localparam logic [8:0] C_AWB     = 9'b000000010;
    localparam logic [8:0] C_BR_T    = 9'b110000001;
    localparam logic [8:0] C_BR_N    = 9'b010000001;

    localparam logic [3:0] A_AND = 4'b0000;
    localparam logic [3:0] A_OR  = 4'b0001;
    localparam logic [3:0] A_ADD = 4'b0010;
    localparam logic [3:0] A_SUB = 4'b0110;

    localparam logic [6:0] O_R   = 7'b0110011;
    localparam logic [6:0] O_I   = 7'b0010011;
    localparam logic [6:0] O_LW  = 7'b0000011;
    localparam logic [6:0] O_SW  = 7'b0100011;
    localparam logic [6:0] O_BEQ = 7'b1100011;
    localparam logic [6:0] O_BAD = 7'b1111111;

    logic       clk;
    logic       reset;
    logic [6:0] Opcode;
    logic [3:0] Funct;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, PCSrc, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [3:0] Operation;
    logic [3:0] state;
    logic       illegal_op;
    logic       mem_timeout;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    multicycle_control #(
        .RESET_STATE (4'd0),
        .MEM_TIMEOUT (8'd4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Opcode      (Opcode),
        .Funct       (Funct),
        .Zero        (Zero),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCSrc       (PCSrc),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .Operation   (Operation),
        .state       (state),
        .illegal_op  (illegal_op),
        .mem_timeout (mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [3:0] st, input logic [8:0] ctl,
                                input logic [1:0] srcb, input logic [3:0] op,
                                input logic ill, input logic tmo);
        mk = {st, ctl, srcb, op, ill, tmo};
    endfunction

    // One clock cycle of stimulus plus its expected output vector.
    task automatic cyc(input logic rst, input logic [6:0] opc, input logic [3:0] fn,
                       input logic z, input logic rdy, input exp_t e, input string nm);
        reset     = rst;
        Opcode    = opc;
        Funct     = fn;
        Zero      = z;
        mem_ready = rdy;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Zero-wait R/I instruction: FETCH, DECODE, EXEC, ALU_WB.
    task automatic alu_instr(input logic [6:0] opc, input logic [3:0] fn,
                             input logic [3:0] ex_st, input logic [1:0] ex_srcb,
                             input logic [3:0] ex_op, input string nm);
        cyc(1'b0, opc, fn, 1'b0, 1'b1, mk(4'd0, C_FETCH_R, 2'b01, A_ADD, 1'b0, 1'b0), {nm, "_fetch"});
        cyc(1'b0, opc, fn, 1'b0, 1'b1, mk(4'd1, C_NONE,    2'b10, A_ADD, 1'b0, 1'b0), {nm, "_decode"});
        cyc(1'b0, opc, fn, 1'b0, 1'b1, mk(ex_st, C_SRCA,   ex_srcb, ex_op, 1'b0, 1'b0), {nm, "_exec"});
        cyc(1'b0, opc, fn, 1'b0, 1'b1, mk(4'd8, C_AWB,     2'b00, A_ADD, 1'b0, 1'b0), {nm, "_wb"});
    endtask

    // Monitor: compare DUT outputs mid-cycle against the scoreboard head.
    always @(negedge clk) begin
        exp_t  e;
        exp_t  act;
        string nm;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {state, PCWrite, PCSrc, IorD, MemRead, MemWrite, IRWrite,
                   MemtoReg, RegWrite, ALUSrcA, ALUSrcB, Operation, illegal_op, mem_timeout};
            n_checks++;
            if (act === e) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got st=%0d ctl=%b srcb=%b op=%b ill=%b tmo=%b, expected st=%0d ctl=%b srcb=%b op=%b ill=%b tmo=%b",
                         nm, act.st, act.ctl, act.srcb, act.op, act.ill, act.tmo,
                         e.st, e.ctl, e.srcb, e.op, e.ill, e.tmo);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        Opcode    = 7'd0;
        Funct     = 4'd0;
        Zero      = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset state: FETCH with every request masked.
        cyc(1'b1, 7'd0, 4'd0, 1'b0, 1'b1, mk(4'd0, C_NONE, 2'b00, A_ADD, 1'b0, 1'b0), "reset_hold");

        // R/I ALU instructions with mem_ready tied high.
        alu_instr(O_R, 4'b0000, 4'd6, 2'b00, A_ADD, "add");
        alu_instr(O_R, 4'b1000, 4'd6, 2'b00, A_SUB, "sub");
        alu_instr(O_R, 4'b0111, 4'd6, 2'b00, A_AND, "and");
        alu_instr(O_R, 4'b0001, 4'd6, 2'b00, A_ADD, "r_unknown");
        alu_instr(O_I, 4'b1110, 4'd7, 2'b10, A_OR,  "ori");
        alu_instr(O_I, 4'b0111, 4'd7, 2'b10, A_AND, "andi");

        // lw with three MEM_RD wait cycles: 8 cycles total.
        cyc(1'b0, O_LW, 4'd0, 1'b0, 1'b1, mk(4'd0, C_FETCH_R, 2'b01, A_ADD, 1'b0, 1'b0), "lw_fetch");
        cyc(1'b0, O_LW, 4'd0, 1'b0, 1'b0, mk(4'd1, C_NONE,    2'b10, A_ADD, 1'b0, 1'b0), "lw_decode");
        cyc(1'b0, O_LW, 4'd0, 1'b0, 1'b0, mk(4'd2, C_SRCA,    2'b10, A_ADD, 1'b0, 1'b0), "lw_addr");
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, O_LW, 4'd0, 1'b0, 1'b0, mk(4'd3, C_MRD, 2'b00, A_ADD, 1'b0, 1'b0), "lw_rd_wait");
        end
        cyc(1'b0, O_LW, 4'd0, 1'b0, 1'b1, mk(4'd3, C_MRD,     2'b00, A_ADD, 1'b0, 1'b0), "lw_rd_done");
        cyc(1'b0, O_LW, 4'd0, 1'b0, 1'b1, mk(4'd4, C_MWB,     2'b00, A_ADD, 1'b0, 1'b0), "lw_wb");

        // beq taken, with one FETCH wait cycle first.
        cyc(1'b0, O_BEQ, 4'd0, 1'b1, 1'b0, mk(4'd0, C_FETCH_W, 2'b01, A_ADD, 1'b0, 1'b0), "beq_fetch_wait");
        cyc(1'b0, O_BEQ, 4'd0, 1'b1, 1'b1, mk(4'd0, C_FETCH_R, 2'b01, A_ADD, 1'b0, 1'b0), "beq_fetch");
        cyc(1'b0, O_BEQ, 4'd0, 1'b1, 1'b1, mk(4'd1, C_NONE,    2'b10, A_ADD, 1'b0, 1'b0), "beq_decode");
        cyc(1'b0, O_BEQ, 4'd0, 1'b1, 1'b1, mk(4'd9, C_BR_T,    2'b00, A_SUB, 1'b0, 1'b0), "beq_taken");
        // beq not taken.
        cyc(1'b0, O_BEQ, 4'd0, 1'b0, 1'b1, mk(4'd0, C_FETCH_R, 2'b01, A_ADD, 1'b0, 1'b0), "beqn_fetch");
        cyc(1'b0, O_BEQ, 4'd0, 1'b0, 1'b1, mk(4'd1, C_NONE,    2'b10, A_ADD, 1'b0, 1'b0), "beqn_decode");
        cyc(1'b0, O_BEQ, 4'd0, 1'b0, 1'b1, mk(4'd9, C_BR_N,    2'b00, A_SUB, 1'b0, 1'b0), "beq_not_taken");

        // sw, zero-wait.
        cyc(1'b0, O_SW, 4'd0, 1'b0, 1'b1, mk(4'd0, C_FETCH_R, 2'b01, A_ADD, 1'b0, 1'b0), "sw_fetch");
        cyc(1'b0, O_SW, 4'd0, 1'b0, 1'b1, mk(4'd1, C_NONE,    2'b10, A_ADD, 1'b0, 1'b0), "sw_decode");
        cyc(1'b0, O_SW, 4'd0, 1'b0, 1'b1, mk(4'd2, C_SRCA,    2'b10, A_ADD, 1'b0, 1'b0), "sw_addr");
        cyc(1'b0, O_SW, 4'd0, 1'b0, 1'b1, mk(4'd5, C_MWR,     2'b00, A_ADD, 1'b0, 1'b0), "sw_wr");

        // Illegal opcode: one pulse in DECODE, then back to FETCH.
        cyc(1'b0, O_BAD, 4'd0, 1'b0, 1'b1, mk(4'd0, C_FETCH_R, 2'b01, A_ADD, 1'b0, 1'b0), "ill_fetch");
        cyc(1'b0, O_BAD, 4'd0, 1'b0, 1'b1, mk(4'd1, C_NONE,    2'b10, A_ADD, 1'b1, 1'b0), "ill_decode");

        // Reset mid-MEM_RD drops the request.
        cyc(1'b0, O_LW, 4'd0, 1'b0, 1'b1, mk(4'd0, C_FETCH_R, 2'b01, A_ADD, 1'b0, 1'b0), "ill_next_fetch");
        cyc(1'b0, O_LW, 4'd0, 1'b0, 1'b0, mk(4'd1, C_NONE,    2'b10, A_ADD, 1'b0, 1'b0), "rst_lw_decode");
        cyc(1'b0, O_LW, 4'd0, 1'b0, 1'b0, mk(4'd2, C_SRCA,    2'b10, A_ADD, 1'b0, 1'b0), "rst_lw_addr");
        cyc(1'b0, O_LW, 4'd0, 1'b0, 1'b0, mk(4'd3, C_MRD,     2'b00, A_ADD, 1'b0, 1'b0), "rst_lw_rd");
        cyc(1'b1, O_LW, 4'd0, 1'b0, 1'b0, mk(4'd3, C_NONE,    2'b00, A_ADD, 1'b0, 1'b0), "rst_mask");
        cyc(1'b1, O_LW, 4'd0, 1'b0, 1'b0, mk(4'd0, C_NONE,    2'b00, A_ADD, 1'b0, 1'b0), "rst_state");

        // sw with mem_ready stuck low: MemWrite 4 cycles, then timeout.
        cyc(1'b0, O_SW, 4'd0, 1'b0, 1'b1, mk(4'd0, C_FETCH_R, 2'b01, A_ADD, 1'b0, 1'b0), "to_fetch");
        cyc(1'b0, O_SW, 4'd0, 1'b0, 1'b0, mk(4'd1, C_NONE,    2'b10, A_ADD, 1'b0, 1'b0), "to_decode");
        cyc(1'b0, O_SW, 4'd0, 1'b0, 1'b0, mk(4'd2, C_SRCA,    2'b10, A_ADD, 1'b0, 1'b0), "to_addr");
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, O_SW, 4'd0, 1'b0, 1'b0, mk(4'd5, C_MWR, 2'b00, A_ADD, 1'b0, 1'b0), "to_wr_wait");
        end
        cyc(1'b0, O_SW, 4'd0, 1'b0, 1'b0, mk(4'd0, C_FETCH_W, 2'b01, A_ADD, 1'b0, 1'b1), "to_flag_set");
        cyc(1'b0, O_SW, 4'd0, 1'b0, 1'b0, mk(4'd0, C_FETCH_W, 2'b01, A_ADD, 1'b0, 1'b1), "to_flag_sticky");
        cyc(1'b1, O_SW, 4'd0, 1'b0, 1'b0, mk(4'd0, C_NONE,    2'b00, A_ADD, 1'b0, 1'b1), "to_reset_cycle");

        // Fetch timeout: four wait cycles, then fetch re-issued with flag set.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, O_SW, 4'd0, 1'b0, 1'b0, mk(4'd0, C_FETCH_W, 2'b01, A_ADD, 1'b0, 1'b0), "fto_wait");
        end
        cyc(1'b0, O_SW, 4'd0, 1'b0, 1'b0, mk(4'd0, C_FETCH_W, 2'b01, A_ADD, 1'b0, 1'b1), "fto_reissue");
        cyc(1'b0, O_SW, 4'd0, 1'b0, 1'b1, mk(4'd0, C_FETCH_R, 2'b01, A_ADD, 1'b0, 1'b1), "fto_complete");

        // Scoreboard must have drained within a few cycles.
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the RV32 subset datapath: R-type, I-type ALU, lw, sw, beq.
- Replaces the single-cycle control path with an FSM that:
  - steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB;
  - drives datapath enables and mux selects per cycle;
  - stalls on a memory-ready handshake.
- Sits between the shared instruction/data memory port, the IR, the register file and the ALU.

Parameters:
- RESET_STATE, 4'd0 (FETCH): state entered on reset.
- MEM_TIMEOUT, 8'd255: maximum cycles to wait on mem_ready before flagging an error. A value of 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; forces RESET_STATE
- Opcode  in  7  IR[6:0]; valid from DECODE onward
- Funct  in  4  {IR[30], IR[14:12]}
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC register load enable
- PCSrc  out  1  0 = ALU result, 1 = ALUOut register (branch target)
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  writeback source: 0 = ALUOut, 1 = MDR
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  0 = PC, 1 = rs1
- ALUSrcB  out  2  00 = rs2, 01 = const 4, 10 = immediate
- Operation  out  4  ALU operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB
- state  out  4  current state, for debug
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- mem_timeout  out  1  sticky; set on wait overflow, cleared only by reset

Behaviour:
- Reset:
  - state = FETCH.
  - All enables 0, all selects 0, Operation = 0010.
  - illegal_op = 0, mem_timeout = 0, wait counter = 0.
  - Reset takes effect on the edge regardless of state, including mid-memory-access. No request is held across reset.
- Outputs are Moore-decoded from state. Exceptions:
  - PCWrite in FETCH is qualified by mem_ready.
  - PCWrite in BRANCH is qualified by Zero.
  - IRWrite is qualified by mem_ready.
- States and transitions:
  - FETCH (0):
    - Outputs: IorD = 0, MemRead = 1, ALUSrcA = 0, ALUSrcB = 01, Operation = ADD.
    - On mem_ready: IRWrite = 1, PCWrite = 1, PCSrc = 0, go to DECODE. Otherwise hold.
  - DECODE (1):
    - Outputs: ALUSrcA = 0, ALUSrcB = 10, Operation = ADD (branch target into ALUOut).
    - Next state by Opcode:
      - 0000011 or 0100011 -> MEM_ADDR
      - 0110011 -> EXEC_R
      - 0010011 -> EXEC_I
      - 1100011 -> BRANCH
      - any other -> FETCH, with illegal_op = 1 for that cycle
  - MEM_ADDR (2): ALUSrcA = 1, ALUSrcB = 10, ADD. Next: lw -> MEM_RD, sw -> MEM_WR.
  - MEM_RD (3): IorD = 1, MemRead = 1. On mem_ready go to MEM_WB.
  - MEM_WB (4): RegWrite = 1, MemtoReg = 1. Next: FETCH.
  - MEM_WR (5): IorD = 1, MemWrite = 1. On mem_ready go to FETCH.
  - EXEC_R (6):
    - ALUSrcA = 1, ALUSrcB = 00.
    - Operation from Funct: 0000 ADD, 1000 SUB, 0111 AND, 0110 OR. Any other Funct gives ADD.
    - Next: ALU_WB.
  - EXEC_I (7):
    - ALUSrcA = 1, ALUSrcB = 10.
    - Operation from Funct[2:0]: 000 ADD, 111 AND, 110 OR. Others give ADD. Funct[3] is ignored.
    - Next: ALU_WB.
  - ALU_WB (8): RegWrite = 1, MemtoReg = 0. Next: FETCH.
  - BRANCH (9):
    - ALUSrcA = 1, ALUSrcB = 00, SUB, PCSrc = 1, PCWrite = Zero.
    - Next: FETCH.
  - Unused encodings 10-15 -> FETCH next cycle, all outputs 0.
- Latency:
  - Every state lasts one cycle, except FETCH, MEM_RD and MEM_WR, which last 1 + wait cycles.
  - With zero-wait memory: lw = 5, sw = 4, R/I = 4, beq = 3 cycles.
- Memory handshake:
  - MemRead/MemWrite stay asserted and stable until the cycle mem_ready = 1, inclusive. They deassert the next cycle.
  - mem_ready outside a memory state is ignored.
- Wait counter:
  - Cleared on entry to any memory state, incremented each cycle mem_ready = 0.
  - When it reaches MEM_TIMEOUT: set mem_timeout, go to FETCH. If the aborted state was FETCH, the fetch is re-issued with a fresh counter.
  - Saturates and never wraps.

Decomposition:
- Package mc_pkg holds:
  - state localparams (4-bit);
  - opcode constants: OP_R, OP_I, OP_LW, OP_SW, OP_BEQ;
  - ALU operation codes: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB;
  - ALUSrcB select codes.
- One sub-module, mc_alu_decode: combinational decode of (state, Funct) to Operation.
- FSM, wait counter and output decode stay in multicycle_control.

Test Plan:
- Reset in MEM_RD with MemRead = 1, then one clock -> state = 0, MemRead = 0, RegWrite = 0.
- add, Opcode = 0110011, Funct = 0000, mem_ready tied 1 -> states 0,1,6,8,0; Operation = 0010 in state 6; RegWrite high only in state 8.
- lw, Opcode = 0000011, mem_ready low for 3 cycles in MEM_RD -> MemRead held 4 cycles; MemtoReg = 1 and RegWrite = 1 for one cycle; total 8 cycles.
- beq, Opcode = 1100011, Zero = 1 then repeat with Zero = 0 -> PCWrite = 1, PCSrc = 1 in state 9 on the first run; PCWrite = 0 in state 9 on the second run.
- Opcode = 1111111 -> illegal_op pulses exactly once in DECODE, next state = 0, no RegWrite/MemWrite.
- MEM_TIMEOUT = 4, sw with mem_ready stuck 0 -> MemWrite held 4 cycles, mem_timeout = 1 and sticky, state returns to 0; reset clears the flag.
